// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - opcodes, field positions and widths shared by the single-cycle datapath
package datapath_pkg;

   localparam int WORD_W = 32;
   localparam int REG_AW = 5;
   localparam int NUM_REGS = 32;

   localparam logic [5:0] OP_ADD = 6'b000001;
   localparam logic [5:0] OP_SW  = 6'b000010;
   localparam logic [5:0] OP_SUB = 6'b000011;
   localparam logic [5:0] OP_LW  = 6'b000100;

   localparam int OP_MSB  = 31;
   localparam int OP_LSB  = 26;
   localparam int RS_MSB  = 25;
   localparam int RS_LSB  = 21;
   localparam int RT_MSB  = 20;
   localparam int RT_LSB  = 16;
   localparam int RD_MSB  = 15;
   localparam int RD_LSB  = 11;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;

endpackage

// File: rtl/dmem.sv
// rtl/dmem.sv - word-addressed data RAM, combinational read, synchronous write, byte offset ignored
module dmem
   import datapath_pkg::*;
#(
   parameter int DEPTH = 256
) (
   input  logic              clk,
   input  logic              we,
   input  logic [WORD_W-1:0] addr,
   input  logic [WORD_W-1:0] wd,
   output logic [WORD_W-1:0] rd
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WORD_W-1:0] Mem [DEPTH];
   logic [29:0]       word_addr;
   logic [AW-1:0]     idx;
   logic              unused_byte_bits;

   assign word_addr        = addr[31:2];
   assign idx              = AW'(word_addr % 30'(DEPTH));
   assign unused_byte_bits = ^addr[1:0];
   assign rd               = Mem[idx];

   always_ff @(posedge clk) begin
      if (we) Mem[idx] <= wd;
   end

endmodule

// File: rtl/regfile.sv
// rtl/regfile.sv - 32x32 register file, two combinational reads, one synchronous write, r0 hardwired to zero
module regfile
   import datapath_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [REG_AW-1:0] ra1,
   input  logic [REG_AW-1:0] ra2,
   input  logic [REG_AW-1:0] wa,
   input  logic [WORD_W-1:0] wd,
   output logic [WORD_W-1:0] rd1,
   output logic [WORD_W-1:0] rd2
);

   logic [WORD_W-1:0] Regs [NUM_REGS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) Regs[i] <= '0;
      end else if (we && (wa != '0)) begin
         Regs[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == '0) ? '0 : Regs[ra1];
   assign rd2 = (ra2 == '0) ? '0 : Regs[ra2];

endmodule

// File: rtl/simple_datapath.sv
// rtl/simple_datapath.sv - single-cycle ADD/LW/SW datapath; DATAPATH_SUB_EN adds SUB on opcode 000011
module simple_datapath
   import datapath_pkg::*;
#(
   parameter int    IMEM_DEPTH = 256,
   parameter int    DMEM_DEPTH = 256,
   parameter string IMEM_FILE  = "imem.hex"
) (
   input  logic              clk,
   input  logic              rst,
   output logic              RegWrite,
   output logic              MemWrite,
   output logic              MemRead,
   output logic [WORD_W-1:0] pc,
   output logic [WORD_W-1:0] instruction,
   output logic [WORD_W-1:0] ReadData2,
   output logic [WORD_W-1:0] ALU_Result
);

   localparam int IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

   logic [WORD_W-1:0] rom [IMEM_DEPTH];

   logic [WORD_W-1:0] pc_q, pc_d;
   logic [29:0]       rom_idx;
   logic              unused_pc_bits;

   assign pc_d = pc_q + 32'd4;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pc_q <= '0;
      else     pc_q <= pc_d;
   end

   assign pc             = pc_q;
   assign rom_idx        = pc_q[31:2];
   assign unused_pc_bits = ^pc_q[1:0];
   assign instruction    = (32'(rom_idx) < IMEM_DEPTH) ? rom[rom_idx[IAW-1:0]] : '0;

   logic [5:0]        op;
   logic [REG_AW-1:0] rs, rt, rd;
   logic [WORD_W-1:0] simm;

   assign op   = instruction[OP_MSB:OP_LSB];
   assign rs   = instruction[RS_MSB:RS_LSB];
   assign rt   = instruction[RT_MSB:RT_LSB];
   assign rd   = instruction[RD_MSB:RD_LSB];
   assign simm = {{16{instruction[IMM_MSB]}}, instruction[IMM_MSB:IMM_LSB]};

   logic alu_use_imm, alu_sub, wr_sel_rt;

   // Enables are held low during reset so nothing commits while rst is high.
   always_comb begin
      RegWrite    = 1'b0;
      MemWrite    = 1'b0;
      MemRead     = 1'b0;
      alu_use_imm = 1'b1;
      alu_sub     = 1'b0;
      wr_sel_rt   = 1'b0;
      if (!rst) begin
         case (op)
            OP_ADD: begin
               RegWrite    = 1'b1;
               alu_use_imm = 1'b0;
            end
            OP_LW: begin
               RegWrite  = 1'b1;
               MemRead   = 1'b1;
               wr_sel_rt = 1'b1;
            end
            OP_SW: MemWrite = 1'b1;
`ifdef DATAPATH_SUB_EN
            OP_SUB: begin
               RegWrite    = 1'b1;
               alu_use_imm = 1'b0;
               alu_sub     = 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

   logic [REG_AW-1:0] regfile_ReadReg1, regfile_ReadReg2, regfile_WriteReg;
   logic [WORD_W-1:0] regfile_ReadData1, regfile_ReadData2, regfile_WriteData;
   logic [WORD_W-1:0] alu_b, mem_rdata;

   assign regfile_ReadReg1 = rs;
   assign regfile_ReadReg2 = rt;
   assign regfile_WriteReg = wr_sel_rt ? rt : rd;

   assign alu_b      = alu_use_imm ? simm : regfile_ReadData2;
   assign ALU_Result = alu_sub ? (regfile_ReadData1 - alu_b) : (regfile_ReadData1 + alu_b);
   assign ReadData2  = regfile_ReadData2;

   assign regfile_WriteData = MemRead ? mem_rdata : ALU_Result;

   regfile rf (
      .clk (clk),
      .rst (rst),
      .we  (RegWrite),
      .ra1 (regfile_ReadReg1),
      .ra2 (regfile_ReadReg2),
      .wa  (regfile_WriteReg),
      .wd  (regfile_WriteData),
      .rd1 (regfile_ReadData1),
      .rd2 (regfile_ReadData2)
   );

   dmem #(.DEPTH(DMEM_DEPTH)) dm (
      .clk  (clk),
      .we   (MemWrite),
      .addr (ALU_Result),
      .wd   (regfile_ReadData2),
      .rd   (mem_rdata)
   );

endmodule

// File: tb/tb_simple_datapath.sv
// tb/tb_simple_datapath.sv - directed vector table plus random programs against an ISA-level model
module tb_simple_datapath;

   localparam int IMEM_DEPTH = 256;
   localparam int DMEM_DEPTH = 256;
`ifdef DATAPATH_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif

   localparam logic [5:0] T_ADD = 6'b000001;
   localparam logic [5:0] T_SW  = 6'b000010;
   localparam logic [5:0] T_SUB = 6'b000011;
   localparam logic [5:0] T_LW  = 6'b000100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        RegWrite, MemWrite, MemRead;
   logic [31:0] pc, instruction, ReadData2, ALU_Result;

   simple_datapath #(
      .IMEM_DEPTH (IMEM_DEPTH),
      .DMEM_DEPTH (DMEM_DEPTH),
      .IMEM_FILE  ("")
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .RegWrite    (RegWrite),
      .MemWrite    (MemWrite),
      .MemRead     (MemRead),
      .pc          (pc),
      .instruction (instruction),
      .ReadData2   (ReadData2),
      .ALU_Result  (ALU_Result)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   logic [31:0] m_regs [32];
   logic [31:0] m_mem  [DMEM_DEPTH];
   logic [31:0] m_rom  [IMEM_DEPTH];
   logic [31:0] mpc;

   logic [31:0] e_instr, e_alu, e_rd2, pend_val;
   logic        e_rw, e_mw, e_mr, e_alu_v;
   int          pend_kind, pend_idx;

   typedef struct {
      string       name;
      logic [31:0] instr;
      int          pre_r;
      logic [31:0] pre_v;
      logic        rw, mw, mr, alu_chk;
      logic [31:0] alu;
      int          kind;
      int          idx;
      logic [31:0] val;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic cmp_regs(input string name);
      int bad = -1;
      for (int i = 0; i < 32; i++) if (bad < 0 && dut.rf.Regs[i] !== m_regs[i]) bad = i;
      total++;
      if (bad < 0) passed++;
      else $display("FAIL %s: Regs[%0d] got %h expected %h", name, bad, dut.rf.Regs[bad], m_regs[bad]);
   endtask

   task automatic cmp_mem(input string name);
      int bad = -1;
      for (int i = 0; i < DMEM_DEPTH; i++) if (bad < 0 && dut.dm.Mem[i] !== m_mem[i]) bad = i;
      total++;
      if (bad < 0) passed++;
      else $display("FAIL %s: Mem[%0d] got %h expected %h", name, bad, dut.dm.Mem[bad], m_mem[bad]);
   endtask

   task automatic set_reg(input int i, input logic [31:0] v);
      dut.rf.Regs[i] = v;
      m_regs[i] = v;
   endtask

   task automatic set_mem(input int i, input logic [31:0] v);
      dut.dm.Mem[i] = v;
      m_mem[i] = v;
   endtask

   task automatic set_rom(input int i, input logic [31:0] v);
      dut.rom[i] = v;
      m_rom[i] = v;
   endtask

   // Architectural effect of one instruction, evaluated from the ISA rules.
   task automatic step_pre(input logic [31:0] instr);
      logic [5:0]  op;
      logic [31:0] a, b, simm;
      int unsigned idx;
      idx = mpc >> 2;
      if (idx < IMEM_DEPTH) begin
         set_rom(int'(idx), instr);
         e_instr = instr;
      end else begin
         e_instr = 32'h0;
      end
      op   = e_instr[31:26];
      a    = m_regs[e_instr[25:21]];
      b    = m_regs[e_instr[20:16]];
      simm = {{16{e_instr[15]}}, e_instr[15:0]};
      e_rw = 0; e_mw = 0; e_mr = 0; e_alu_v = 0; e_alu = 0; e_rd2 = b;
      pend_kind = 0; pend_idx = 0; pend_val = 0;
      if (op == T_ADD || (op == T_SUB && SUB_EN)) begin
         e_rw = 1; e_alu_v = 1;
         e_alu = (op == T_ADD) ? a + b : a - b;
         pend_kind = 1; pend_idx = int'(e_instr[15:11]); pend_val = e_alu;
      end else if (op == T_LW) begin
         e_rw = 1; e_mr = 1; e_alu_v = 1; e_alu = a + simm;
         pend_kind = 1; pend_idx = int'(e_instr[20:16]);
         pend_val = m_mem[(e_alu >> 2) % DMEM_DEPTH];
      end else if (op == T_SW) begin
         e_mw = 1; e_alu_v = 1; e_alu = a + simm;
         pend_kind = 2; pend_idx = int'((e_alu >> 2) % DMEM_DEPTH); pend_val = b;
      end
      #1;
      chk("pc", pc, mpc);
      chk("instruction", instruction, e_instr);
      chk("RegWrite", 32'(RegWrite), 32'(e_rw));
      chk("MemWrite", 32'(MemWrite), 32'(e_mw));
      chk("MemRead", 32'(MemRead), 32'(e_mr));
      chk("ReadData2", ReadData2, e_rd2);
      if (e_alu_v) chk("ALU_Result", ALU_Result, e_alu);
   endtask

   task automatic step_post();
      @(posedge clk);
      #1;
      if (pend_kind == 1 && pend_idx != 0) m_regs[pend_idx] = pend_val;
      if (pend_kind == 2) m_mem[pend_idx] = pend_val;
      mpc = mpc + 32'd4;
      cmp_regs("regs_after_step");
      cmp_mem("mem_after_step");
   endtask

   initial begin
      vec_t tbl [8];
      logic [31:0] ri;

      for (int i = 0; i < IMEM_DEPTH; i++) set_rom(i, 32'h0);
      for (int i = 0; i < DMEM_DEPTH; i++) set_mem(i, $urandom);
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      mpc = 32'h0;
      set_rom(0, 32'h052A4000);

      repeat (2) @(posedge clk);
      #1;
      chk("reset_pc", pc, 32'h0);
      chk("reset_instruction", instruction, 32'h052A4000);
      chk("reset_RegWrite", 32'(RegWrite), 32'h0);
      chk("reset_MemWrite", 32'(MemWrite), 32'h0);
      chk("reset_MemRead", 32'(MemRead), 32'h0);
      cmp_regs("reset_regs");
      rst = 1'b0;

      set_reg(9, 32'hA);
      set_reg(10, 32'h14);
      set_reg(16, 32'h50);
      set_reg(18, 32'h64);
      set_mem(1, 32'h200);
      set_mem(65, 32'hCAFE0001);

      tbl[0] = '{name:"add", instr:32'h052A4000, pre_r:0, pre_v:0, rw:1, mw:0, mr:0,
                 alu_chk:1, alu:32'h1E, kind:1, idx:8, val:32'h1E};
      tbl[1] = '{name:"lw", instr:32'h10090004, pre_r:0, pre_v:0, rw:1, mw:0, mr:1,
                 alu_chk:1, alu:32'h4, kind:1, idx:9, val:32'h200};
      tbl[2] = '{name:"sw_neg", instr:32'h0952FFFC, pre_r:10, pre_v:32'h104, rw:0, mw:1, mr:0,
                 alu_chk:1, alu:32'h100, kind:2, idx:64, val:32'h64};
      tbl[3] = '{name:"lw_wrap", instr:32'h11450400, pre_r:0, pre_v:0, rw:1, mw:0, mr:1,
                 alu_chk:1, alu:32'h504, kind:1, idx:5, val:32'hCAFE0001};
      tbl[4] = '{name:"add_r0", instr:32'h052A0000, pre_r:0, pre_v:0, rw:1, mw:0, mr:0,
                 alu_chk:1, alu:32'h304, kind:1, idx:0, val:32'h0};
      tbl[5] = '{name:"nop_zero", instr:32'h00000000, pre_r:0, pre_v:0, rw:0, mw:0, mr:0,
                 alu_chk:0, alu:0, kind:1, idx:8, val:32'h1E};
      tbl[6] = '{name:"nop_undef", instr:32'hFD2A4000, pre_r:0, pre_v:0, rw:0, mw:0, mr:0,
                 alu_chk:0, alu:0, kind:1, idx:8, val:32'h1E};
      tbl[7] = '{name:"sub", instr:32'h0E304000, pre_r:17, pre_v:32'h5A, rw:SUB_EN, mw:0, mr:0,
                 alu_chk:SUB_EN, alu:32'hA, kind:1, idx:8, val:(SUB_EN ? 32'hA : 32'h1E)};

      for (int t = 0; t < 8; t++) begin
         if (tbl[t].pre_r != 0) set_reg(tbl[t].pre_r, tbl[t].pre_v);
         step_pre(tbl[t].instr);
         chk({tbl[t].name, "_RegWrite"}, 32'(RegWrite), 32'(tbl[t].rw));
         chk({tbl[t].name, "_MemWrite"}, 32'(MemWrite), 32'(tbl[t].mw));
         chk({tbl[t].name, "_MemRead"}, 32'(MemRead), 32'(tbl[t].mr));
         if (tbl[t].alu_chk) chk({tbl[t].name, "_ALU"}, ALU_Result, tbl[t].alu);
         step_post();
         if (tbl[t].kind == 1) chk({tbl[t].name, "_reg"}, dut.rf.Regs[tbl[t].idx], tbl[t].val);
         else chk({tbl[t].name, "_mem"}, dut.dm.Mem[tbl[t].idx], tbl[t].val);
      end

      // Mid-program reset with a store sitting at address 0.
      set_rom(0, 32'h08120008);
      rst = 1'b1;
      #1;
      chk("async_pc", pc, 32'h0);
      chk("async_MemWrite", 32'(MemWrite), 32'h0);
      chk("async_RegWrite", 32'(RegWrite), 32'h0);
      chk("async_MemRead", 32'(MemRead), 32'h0);
      chk("async_instruction", instruction, 32'h08120008);
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("hold_pc", pc, 32'h0);
      cmp_regs("hold_regs");
      cmp_mem("hold_mem");
      rst = 1'b0;
      mpc = 32'h0;
      step_pre(32'h08120008);
      step_post();
      step_pre(32'h0);
      step_post();
      step_pre(32'h0);
      step_post();

      for (int i = 1; i < 32; i++) set_reg(i, $urandom);
      for (int n = 0; n < 300; n++) begin
         ri = $urandom;
         case ($urandom_range(0, 5))
            0: ri[31:26] = T_ADD;
            1: ri[31:26] = T_LW;
            2: ri[31:26] = T_SW;
            3: ri[31:26] = T_SUB;
            4: ri = 32'h0;
            default: ;
         endcase
         step_pre(ri);
         step_post();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
